// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and defaults for the round-robin APB master.
package apb_arb_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // One requester command at the default bus widths.
    typedef struct packed {
        logic              write;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: stateless round-robin picker. The caller owns the pointer
// (last granted id); the search starts at pointer+1 and wraps.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] pointer,
    input  logic                    enable,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] id
);

    localparam int IW = $clog2(NREQ);

    // First set request after the pointer wins; nothing is granted while disabled.
    always_comb begin
        logic found;
        int   idx;
        // NOTE: combinational logic uses blocking '=' and gives every output a default first, so no latch is inferred.
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(pointer) + i) % NREQ;
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: shares one APB bus among NREQ requesters. Commands are
// accepted round-robin, run through SETUP/ACCESS with wait states and an
// optional timeout, and complete with a one-cycle tagged response pulse.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_write,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_wdata,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [DW-1:0]           rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [AW-1:0]           PAddr,
    output logic                    PWrite,
    output logic                    PSel,
    output logic                    PEnable,
    output logic [DW-1:0]           PWData,
    input  logic [DW-1:0]           PRData,
    input  logic                    PReady
);

    localparam int IW = $clog2(NREQ);
    // The wait counter only has to reach TIMEOUT-1 before the timeout fires.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur_id;
    logic [CW-1:0]   wait_cnt;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_id;
    logic            timeout_hit;
    logic            xfer_end;
    logic            window;
    logic            accept;

    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // The current ACCESS cycle is the TIMEOUT-th one and the slave is still stalling.
    assign timeout_hit = (TIMEOUT > 0) && (state == ACCESS) && !PReady && (wait_cnt == WAIT_LAST);
    assign xfer_end    = (state == ACCESS) && (PReady || timeout_hit);
    // New commands are taken when idle or on the edge the running transfer ends.
    assign window      = (state == IDLE) || xfer_end;
    assign accept      = |grant;
    assign req_ready   = grant;
    assign busy        = (state != IDLE);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req_valid),
        .pointer (ptr),
        .enable  (window),
        .grant   (grant),
        .id      (grant_id)
    );

    // Route the granted requester's command fields to the bus registers.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // APB phase sequencer with registered bus and response outputs.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            cur_id    <= '0;
            wait_cnt  <= '0;
            PSel      <= 1'b0;
            PEnable   <= 1'b0;
            PWrite    <= 1'b0;
            PAddr     <= '0;
            PWData    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking '<='; a later assignment in this block overrides an earlier one at the same edge.
            rsp_valid <= 1'b0;
            if (xfer_end) begin
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
                rsp_err   <= !PReady;
                rsp_rdata <= (PWrite || !PReady) ? '0 : PRData;
            end

            case (state)
                SETUP: begin
                    PEnable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (xfer_end) begin
                        PSel    <= 1'b0;
                        PEnable <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            // A fresh accept takes precedence over the ACCESS close-out above,
            // which keeps PSel high across back-to-back transfers.
            if (accept) begin
                PSel    <= 1'b1;
                PEnable <= 1'b0;
                PWrite  <= sel_write;
                PAddr   <= sel_addr;
                PWData  <= sel_wdata;
                cur_id  <= grant_id;
                ptr     <= grant_id;
                state   <= SETUP;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of arbitration and timing.
module tb_apb_master_arb;
    import apb_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int AW      = DEF_AW;
    localparam int DW      = DEF_DW;
    localparam int TIMEOUT = 8;
    localparam int IW      = $clog2(NREQ);

    logic               clk = 1'b0;
    logic               Rst = 1'b1;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic               rsp_valid;
    logic [IW-1:0]      rsp_id;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               busy;
    logic [AW-1:0]      PAddr;
    logic               PWrite;
    logic               PSel;
    logic               PEnable;
    logic [DW-1:0]      PWData;
    logic [DW-1:0]      PRData;
    logic               PReady;

    always #5 clk = ~clk;

    apb_master_arb #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .PAddr     (PAddr),
        .PWrite    (PWrite),
        .PSel      (PSel),
        .PEnable   (PEnable),
        .PWData    (PWData),
        .PRData    (PRData),
        .PReady    (PReady)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- APB slave: memory with a programmable wait count ----------------
    logic [DW-1:0] smem [0:65535];
    int            acc_cnt;
    int            wait_cfg = 0;

    assign PReady = (acc_cnt >= wait_cfg);
    assign PRData = smem[PAddr];

    always @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            acc_cnt <= 0;
        end else if (PSel && PEnable) begin
            if (PReady) begin
                acc_cnt <= 0;
                if (PWrite) smem[PAddr] <= PWData;
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    // ---------------- requester agents ----------------
    bit              pend_v   [NREQ];
    bit              hold     [NREQ];
    int              reload   [NREQ];
    cmd_t            pend_cmd [NREQ];
    logic [NREQ-1:0] hs_mask = '0;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]             = pend_v[i] && !hold[i];
            req_write[i]             = pend_cmd[i].write;
            req_addr[i*AW +: AW]     = pend_cmd[i].addr;
            req_wdata[i*DW +: DW]    = pend_cmd[i].wdata;
        end
    endtask

    task automatic load(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend_v[i]   = 1'b1;
        hold[i]     = 1'b0;
        pend_cmd[i] = '{write: w, addr: a, wdata: d};
        drive();
    endtask

    // Advance one cycle; retire accepted commands and optionally reissue.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_mask[i]) begin
                pend_v[i] = 1'b0;
                if (reload[i] > 0) begin
                    reload[i]--;
                    pend_v[i]   = 1'b1;
                    pend_cmd[i] = '{write: 1'b1, addr: AW'($urandom_range(0, 31)), wdata: $urandom};
                end
            end
        end
        drive();
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int            id;
        logic [DW-1:0] rdata;
        bit            err;
        int            due;
    } rsp_t;

    logic [DW-1:0] mmem [int];
    rsp_t          exp_q [$];
    int            grant_log [$];
    logic [DW-1:0] last_rdata [NREQ];
    bit            last_err   [NREQ];
    bit            in_flight = 0;
    int            acc_edge  = 0;
    int            done_cyc  = 0;
    cmd_t          cur_cmd;
    int            mptr      = NREQ - 1;
    int            cyc       = 0;

    always @(posedge clk) cyc++;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Per-cycle comparison of bus and response outputs, then prediction of the next edge.
    always @(negedge clk) begin : monitor
        int              pick;
        int              eff;
        bit              win;
        bit              exp_now;
        bit              terr;
        logic [NREQ-1:0] exp_rdy;
        logic [DW-1:0]   rd;
        rsp_t            r;
        if (!Rst) begin
            in_flight = 0;
            exp_q.delete();
            mptr    = NREQ - 1;
            hs_mask = '0;
        end else begin
            exp_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("rsp_valid", rsp_valid, exp_now);
            if (rsp_valid) begin
                last_rdata[rsp_id] = rsp_rdata;
                last_err[rsp_id]   = rsp_err;
            end
            if ((exp_q.size() > 0) && (exp_q[0].due <= cyc)) begin
                r = exp_q.pop_front();
                if (rsp_valid) begin
                    check("rsp_id", rsp_id, r.id);
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    check("rsp_err", rsp_err, r.err);
                end
            end

            check("psel", PSel, in_flight);
            check("penable", PEnable, in_flight && (cyc != acc_edge));
            check("busy", busy, in_flight);
            if (in_flight) begin
                check("paddr", PAddr, cur_cmd.addr);
                check("pwrite", PWrite, cur_cmd.write);
                if (cur_cmd.write) check("pwdata", PWData, cur_cmd.wdata);
            end

            win  = !in_flight || (done_cyc == cyc + 1);
            pick = win ? rr_pick(req_valid, mptr) : -1;
            exp_rdy = '0;
            if (pick >= 0) exp_rdy[pick] = 1'b1;
            check("req_ready", req_ready, exp_rdy);

            hs_mask = req_valid & req_ready;
            for (int k = 0; k < NREQ; k++) if (hs_mask[k]) grant_log.push_back(k);

            if (in_flight && (done_cyc == cyc + 1)) in_flight = 0;
            if (pick >= 0) begin
                terr     = (wait_cfg >= TIMEOUT);
                eff      = terr ? TIMEOUT - 1 : wait_cfg;
                cur_cmd  = pend_cmd[pick];
                acc_edge = cyc + 1;
                done_cyc = cyc + 3 + eff;
                mptr     = pick;
                in_flight = 1;
                rd = '0;
                if (cur_cmd.write) begin
                    if (!terr) mmem[int'(cur_cmd.addr)] = cur_cmd.wdata;
                end else if (!terr && mmem.exists(int'(cur_cmd.addr))) begin
                    rd = mmem[int'(cur_cmd.addr)];
                end
                exp_q.push_back('{id: pick, rdata: rd, err: terr, due: done_cyc});
            end
        end
    end

    task automatic wait_idle(input int max_cyc);
        bit idle = 1'b0;
        for (int n = 0; n < max_cyc && !idle; n++) begin
            tick();
            idle = !in_flight && (exp_q.size() == 0) && !any_pend();
        end
        check("wait_idle", idle, 1'b1);
    endtask

    task automatic wait_for_grant(input int i, input int max_cyc);
        for (int n = 0; n < max_cyc && pend_v[i]; n++) tick();
        check("grant_wait", pend_v[i], 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int wsel [9]      = '{0, 0, 0, 1, 2, 3, 7, 8, 12};
        bit seen;

        for (int a = 0; a < 65536; a++) smem[a] = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend_v[i] = 0; hold[i] = 0; reload[i] = 0;
            pend_cmd[i] = '0; last_rdata[i] = '0; last_err[i] = 0;
        end
        drive();

        // Reset values.
        #2 Rst = 1'b0;
        #1;
        check("rst_psel", PSel, 1'b0);
        check("rst_penable", PEnable, 1'b0);
        check("rst_pwrite", PWrite, 1'b0);
        check("rst_paddr", PAddr, '0);
        check("rst_pwdata", PWData, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, '0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 Rst = 1'b1;

        // Requester 0 writes 0x50 <- 0x50.
        load(0, 1'b1, 16'h0050, 32'h0000_0050);
        wait_idle(20);
        check("mem_0x50", smem[16'h0050], 32'h0000_0050);

        // Write 0x10 from requester 0; requester 2 pulses valid mid-transfer.
        load(0, 1'b1, 16'h0010, 32'h1234_5678);
        wait_for_grant(0, 10);
        load(2, 1'b0, 16'h0044, '0);
        tick();
        pend_v[2] = 1'b0;
        drive();
        wait_idle(20);

        // Pointer still at 0: requester 1 must beat requester 3. Two wait states each.
        wait_cfg = 2;
        grant_log.delete();
        load(1, 1'b0, 16'h0010, '0);
        load(3, 1'b0, 16'h0050, '0);
        wait_idle(40);
        check("wd_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("wd_first", grant_log[0], 1);
            check("wd_second", grant_log[1], 3);
        end
        check("rd_0x10", last_rdata[1], 32'h1234_5678);
        check("rd_0x10_err", last_err[1], 1'b0);
        check("rd_0x50", last_rdata[3], 32'h0000_0050);

        // Slave stuck low: both queued commands time out back-to-back.
        wait_cfg = 1000;
        load(1, 1'b1, 16'h0020, 32'hDEAD_BEEF);
        load(2, 1'b0, 16'h0010, '0);
        wait_idle(60);
        check("to_err", last_err[2], 1'b1);
        check("to_rdata", last_rdata[2], '0);
        check("to_wr_err", last_err[1], 1'b1);
        check("to_no_write", smem[16'h0020], '0);

        // Reset during an ACCESS wait state.
        load(3, 1'b0, 16'h0050, '0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            seen = PSel && PEnable;
        end
        check("reach_access", seen, 1'b1);
        tick();
        tick();
        #1 Rst = 1'b0;
        #1;
        check("mid_rst_psel", PSel, 1'b0);
        check("mid_rst_penable", PEnable, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 Rst = 1'b1;
        wait_cfg = 0;

        // All four requesters valid continuously: 0,1,2,3 then 0 again.
        grant_log.delete();
        reload[0] = 1;
        for (int i = 0; i < NREQ; i++) load(i, 1'b0, AW'(16'h0050 + i), '0);
        wait_idle(40);
        check("rr_count", grant_log.size(), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) check("rr_order", grant_log[k], exp_order[k]);

        // Randomized traffic with withdrawals and varied wait states.
        for (int n = 0; n < 800; n++) begin
            tick();
            if (!in_flight && ($urandom_range(0, 3) == 0)) wait_cfg = wsel[$urandom_range(0, 8)];
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        load(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
                end else begin
                    hold[i] = ($urandom_range(0, 7) == 0);
                end
            end
            drive();
        end
        for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
        drive();
        wait_idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Multi-requester APB master that shares one APB bus (PAddr/PWrite/PSel/PEnable/PWData) among NREQ testbench or RTL requesters. It accepts single read/write commands over per-requester valid/ready handshakes and arbitrates round-robin. It sequences each command through the APB SETUP and ACCESS phases, honouring PReady wait states with an optional timeout, and returns read data tagged with the requester id. It sits between stimulus agents or CPU-side masters and the APB memory/peripheral slave.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 16, APB address width
- DW, 32, APB data width
- TIMEOUT, 0, max ACCESS cycles before error termination; 0 = wait forever

Ports:
- clk  in  1  clock
- Rst  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  command present, one bit per requester
- req_ready  out  NREQ  command accepted this cycle (combinational, one-hot or zero)
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  $clog2(NREQ)  requester that owned the completed transfer
- rsp_rdata  out  DW  PRData captured at completion (reads), 0 for writes
- rsp_err  out  1  completion was a timeout
- busy  out  1  state != IDLE
- PAddr, PWrite, PSel, PEnable, PWData  out  AW,1,1,1,DW  APB master signals, all registered
- PRData  in  DW  slave read data
- PReady  in  1  slave ready; tie to 1 for zero-wait slaves

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- Accept window: state IDLE, or state ACCESS with PReady=1 (back-to-back). The window also opens at a timeout termination.
- In an accept window, the winner among set req_valid bits gets req_ready=1. A command transfers at the edge where req_valid & req_ready is high.
- On accept, the block latches addr, wdata and write into the APB outputs. It sets PSel=1, PEnable=0 and goes to SETUP.
- SETUP: next edge sets PEnable=1 and goes to ACCESS.
- ACCESS, PReady=1:
  - Completion: rsp_valid=1 next cycle, with rsp_id, rsp_rdata and rsp_err=0.
  - If another command is accepted on the same edge, go to SETUP with the new fields and PEnable=0.
  - Otherwise set PSel=0, PEnable=0 and go to IDLE.
- ACCESS, PReady=0: hold all APB outputs. The wait counter increments.
- If TIMEOUT>0 and the counter reaches TIMEOUT: complete with rsp_err=1 and rsp_rdata=0. Then behave as for PReady=1.
- Round-robin: a pointer holds the last granted id. Search starts at pointer+1 mod NREQ. The pointer updates only on accept.
- req_valid dropping before accept is a legal withdrawal. Fields are don't-care once accepted.
- Asynchronous reset:
  - Outputs: PSel=0, PEnable=0, PWrite=0, PAddr=0, PWData=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Internal: pointer=NREQ-1 (requester 0 wins first), wait counter=0, state IDLE.
  - An in-flight transfer is dropped with no response.

## Timing
- Accept at edge E0. PSel rises after E0. PEnable rises after E1.
- With PReady=1 at E2, rsp_valid is high E2..E3. This is the minimum 3-cycle latency.
- Back-to-back throughput is one transfer per 2 cycles. PSel stays high across them.
- Each wait state adds one cycle. A timeout completes at the edge where the ACCESS count equals TIMEOUT.
- PAddr, PWrite and PWData are stable from SETUP through the final ACCESS cycle.

## Structure
- Package apb_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS)
  - default AW/DW localparams
  - a command struct {write, addr, wdata}
- Sub-module rr_arbiter (NREQ parameter): inputs req, pointer, enable; outputs one-hot grant and encoded id. Purely combinational plus no state; the pointer lives in the parent.

## Test plan
- Reset, then requester 0 writes addr 0x50, data 0x50.
  - Expected: PSel/PEnable sequence 1/0 then 1/1, rsp_valid 3 cycles after accept, rsp_id=0.
  - Slave memory[0x50]=0x50.
- Write 0x1234_5678 to 0x10, then read 0x10 with PReady held low 2 cycles.
  - Expected: read completes 5 cycles after accept, rsp_rdata=0x1234_5678, rsp_err=0.
- All 4 requesters valid continuously.
  - Expected: grants in order 0,1,2,3,0. PSel never drops between transfers. One rsp_valid every 2 cycles.
- TIMEOUT=8 with PReady stuck 0.
  - Expected: rsp_err=1 and rsp_rdata=0 after 8 ACCESS cycles. Next queued command then starts SETUP.
- Rst low during an ACCESS wait state.
  - Expected: PSel/PEnable=0 immediately, no rsp_valid.
  - After release, requester 0 wins the first arbitration.
- Requester 2 raises then drops req_valid while a transfer is in progress.
  - Expected: no grant to 2, and the pointer is unchanged.
